// File: rtl/phy_rx_pkg.sv
// Shared definitions for the multi-lane receive PHY: default symbols and lane FSM states.
package phy_rx_pkg;

    localparam logic [7:0] DEF_COMMA = 8'hBC;
    localparam logic [7:0] DEF_IDLE  = 8'h7C;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2
    } lane_state_e;

endpackage

// File: rtl/phy_rx_lane_align.sv
// One serial lane: shift register, symbol boundary counter, comma lock FSM and
// a strobe marking each on-boundary data symbol once locked.
module phy_rx_lane_align
    import phy_rx_pkg::*;
#(
    parameter int                WIDTH      = 8,
    parameter logic [WIDTH-1:0]  COMMA      = WIDTH'(DEF_COMMA),
    parameter logic [WIDTH-1:0]  IDLE       = WIDTH'(DEF_IDLE),
    parameter int                LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             resync,
    input  logic             din,
    output logic             locked,
    output logic             sym_vld,
    output logic [WIDTH-1:0] sym
);

    localparam int FW = $clog2(WIDTH + 1);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CW = $clog2(LOCK_COUNT + 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    lane_state_e      state_q, state_d;
    logic             boundary, is_comma;

    always_comb begin
        sr_d     = {sr_q[WIDTH-2:0], din};
        fill_d   = (fill_q == FW'(WIDTH)) ? fill_q : fill_q + FW'(1);
        boundary = (bit_q == BW'(WIDTH - 1));
        bit_d    = boundary ? '0 : bit_q + BW'(1);
        is_comma = (sr_q == COMMA);
        state_d  = state_q;
        cnt_d    = cnt_q;
        sym_vld  = 1'b0;
        case (state_q)
            HUNT: begin
                // The cycle the comma is seen is treated as the boundary itself.
                if (fill_q == FW'(WIDTH) && is_comma) begin
                    bit_d   = '0;
                    cnt_d   = CW'(1);
                    state_d = (LOCK_COUNT == 1) ? LOCKED : ALIGN;
                end
            end
            ALIGN: begin
                if (boundary) begin
                    if (is_comma) begin
                        cnt_d = cnt_q + CW'(1);
                        if (cnt_q + CW'(1) == CW'(LOCK_COUNT)) state_d = LOCKED;
                    end else begin
                        cnt_d   = '0;
                        state_d = HUNT;
                    end
                end
            end
            LOCKED: sym_vld = boundary && !is_comma && (sr_q != IDLE);
            default: state_d = HUNT;
        endcase
        if (resync) begin
            sr_d    = '0;
            fill_d  = '0;
            bit_d   = '0;
            cnt_d   = '0;
            state_d = HUNT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q    <= '0;
            fill_q  <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            state_q <= HUNT;
        end else begin
            sr_q    <= sr_d;
            fill_q  <= fill_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign locked = (state_q == LOCKED);
    assign sym    = sr_q;

endmodule

// File: rtl/phy_rx_lanes.sv
// N-lane receive PHY: per-lane alignment, per-lane skew FIFOs and a round-robin
// unstriper that waits on the current lane until it has a symbol.
module phy_rx_lanes
    import phy_rx_pkg::*;
#(
    parameter int               LANES      = 2,
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] COMMA      = WIDTH'(DEF_COMMA),
    parameter logic [WIDTH-1:0] IDLE       = WIDTH'(DEF_IDLE),
    parameter int               LOCK_COUNT = 4,
    parameter int               DEPTH      = 4
) (
    input  logic             clk_8f,
    input  logic             reset,
    input  logic [LANES-1:0] data_in,
    input  logic             resync,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic [LANES-1:0] lane_locked,
    output logic             active,
    output logic [LANES-1:0] overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [AW:0] PTR_ONE = 1;

    logic [LANES-1:0]                       sym_vld;
    logic [LANES-1:0][WIDTH-1:0]            sym;
    logic [LANES-1:0][DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [LANES-1:0][AW:0]                 wptr_q, wptr_d, rptr_q, rptr_d;
    logic [LANES-1:0]                       ovf_q, ovf_d;
    logic [LANES-1:0]                       empty, full, pop;
    logic [PW-1:0]                          rr_q, rr_d;
    logic                                   valid_q, valid_d;
    logic [WIDTH-1:0]                       dout_q, dout_d;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        phy_rx_lane_align #(
            .WIDTH      (WIDTH),
            .COMMA      (COMMA),
            .IDLE       (IDLE),
            .LOCK_COUNT (LOCK_COUNT)
        ) u_align (
            .clk     (clk_8f),
            .rst     (reset),
            .resync  (resync),
            .din     (data_in[l]),
            .locked  (lane_locked[l]),
            .sym_vld (sym_vld[l]),
            .sym     (sym[l])
        );
    end

    assign active = &lane_locked;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        ovf_d   = ovf_q;
        rr_d    = rr_q;
        valid_d = 1'b0;
        dout_d  = dout_q;
        empty   = '0;
        full    = '0;
        pop     = '0;
        for (int l = 0; l < LANES; l++) begin
            empty[l] = (wptr_q[l] == rptr_q[l]);
            full[l]  = (wptr_q[l][AW] != rptr_q[l][AW]) &&
                       (wptr_q[l][AW-1:0] == rptr_q[l][AW-1:0]);
            pop[l]   = active && (rr_q == PW'(l)) && !empty[l];
            if (pop[l]) begin
                dout_d    = mem_q[l][rptr_q[l][AW-1:0]];
                valid_d   = 1'b1;
                rptr_d[l] = rptr_q[l] + PTR_ONE;
                rr_d      = (l == LANES - 1) ? '0 : PW'(l + 1);
            end
            // A pop in the same cycle frees the slot, so a full FIFO still accepts.
            if (sym_vld[l]) begin
                if (full[l] && !pop[l]) begin
                    ovf_d[l] = 1'b1;
                end else begin
                    mem_d[l][wptr_q[l][AW-1:0]] = sym[l];
                    wptr_d[l] = wptr_q[l] + PTR_ONE;
                end
            end
        end
        if (resync) begin
            wptr_d  = '0;
            rptr_d  = '0;
            ovf_d   = '0;
            rr_d    = '0;
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_8f or posedge reset) begin
        if (reset) begin
            mem_q   <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            ovf_q   <= '0;
            rr_q    <= '0;
            valid_q <= 1'b0;
            dout_q  <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            ovf_q   <= ovf_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
            dout_q  <= dout_d;
        end
    end

    assign data_out  = dout_q;
    assign valid_out = valid_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/phy_rx_lanes.md
Name: phy_rx_lanes

Overview:
Parametrised receive PHY: LANES serial bit streams, all sampled on one clock, are each comma-aligned and deserialised. Data bytes are buffered per lane, and the round-robin unstriper merges them back into a single WIDTH-bit stream. It is the single-clock, N-lane successor of the two-lane receive path, with bit-alignment search, lock qualification, skew-tolerant per-lane FIFOs, resync and overflow reporting.

Parameters:
LANES, 2, number of serial lanes (1..8)
WIDTH, 8, symbol width in bits; LANES <= WIDTH
COMMA, 8'hBC, alignment symbol (WIDTH bits)
IDLE, 8'h7C, idle filler symbol, never forwarded
LOCK_COUNT, 4, consecutive on-boundary commas required for lock (>=1)
DEPTH, 4, per-lane FIFO entries (power of 2, >=2)

Ports:
clk_8f  in  1  bit clock; all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
data_in  in  LANES  serial bit per lane, MSB-first symbols
resync  in  1  synchronous pulse; forces full realignment
data_out  out  WIDTH  unstriped data symbol
valid_out  out  1  data_out valid this cycle
lane_locked  out  LANES  per-lane lock status
active  out  1  AND of lane_locked
overflow  out  LANES  sticky per-lane FIFO overflow

Behaviour:
- Reset: all outputs 0, lane FSMs in HUNT, FIFOs empty, RR pointer 0, shift registers 0, bit-fill counters 0.
- Per lane, each cycle: shift register <= {sr[WIDTH-2:0], data_in[l]}; the fill counter saturates at WIDTH.
- Lane FSM HUNT: when fill==WIDTH and sr==COMMA, a boundary is set here (bit counter restarts at 0), comma count = 1, go to ALIGN. If LOCK_COUNT==1, go directly to LOCKED.
- ALIGN: at each boundary (every WIDTH cycles), sr==COMMA increments the count. Reaching LOCK_COUNT moves to LOCKED. Any other symbol returns to HUNT with count 0.
- LOCKED: lane_locked[l]=1 and lock is held until reset/resync. At each boundary, a symbol equal to COMMA or IDLE is discarded; any other symbol is written to lane FIFO l on the next edge.
- FIFO write while full: the symbol is dropped, overflow[l] is set (sticky), and contents are unchanged. A write and pop in the same cycle while full is legal; no drop occurs.
- Unstriper runs only while active==1. Each cycle, if FIFO[ptr] is non-empty, it pops, drives data_out and sets valid_out=1, then ptr=(ptr+1) mod LANES. Otherwise valid_out=0 and ptr holds, which waits out lane skew. Output order is therefore lane 0,1,..,LANES-1,0,...
- Latency: last bit of a data symbol sampled at edge E, FIFO write at E+1, data_out/valid_out registered at E+2 (FIFO empty, ptr on that lane).
- When active drops to 0 (via resync), valid_out=0 the next cycle.
- resync=1: on that edge all lanes go to HUNT, FIFOs empty, ptr=0, overflow cleared, fill counters 0, valid_out=0. resync takes priority over any simultaneous write or pop.
- Reset asserted mid-stream clears everything immediately (async). The first symbol after deassertion requires a full HUNT/ALIGN.
- A comma appearing off-boundary in LOCKED is ignored; no realignment occurs without resync.

Decomposition:
- Shared package phy_rx_pkg: default COMMA/IDLE constants and the lane FSM state encoding (HUNT, ALIGN, LOCKED).
- Sub-module phy_rx_lane_align (one per lane via generate): shift register, bit counter, lane FSM, symbol-valid strobe.
- FIFOs and the unstriper live in the top.

Test Plan:
- Lock: LANES=2, both lanes send 4x 8'hBC aligned -> lane_locked=2'b11 at the 4th boundary, active=1, valid_out stays 0 for BC/7C.
- Bit offset: lane 1 is preceded by 3 junk bits then commas -> locks 3 cycles after lane 0. Data A1 (lane0), B2 (lane1), C3 (lane0) -> data_out sequence A1,B2,C3 with no duplicates.
- Broken alignment: 3 commas then 8'h55 on lane 0 -> lane 0 returns to HUNT, lane_locked[0]=0, active=0, no valid_out.
- Overflow: DEPTH=4; lane 1 stalled (IDLE only) while lane 0 sends 6 data symbols -> overflow[0]=1 and data_out emits 1 symbol from lane 0 then waits. The overflow flag survives until resync.
- Resync mid-data: pulse resync with FIFOs non-empty -> next cycle lane_locked=0, overflow=0, valid_out=0; a new comma train relocks normally.
- Async reset: assert reset between clock edges during LOCKED -> outputs 0 immediately, without waiting for an edge.
